// File: rtl/fso_align_ctrl_pkg.sv
// Shared state encoding and default tuning values for the FSO alignment controller.
package fso_align_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SLIP      = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_LOCKED    = 3'd5,
    ST_FAIL      = 3'd6
  } state_t;

  localparam int unsigned DEF_SRST_CYCLES   = 8;
  localparam int unsigned DEF_LOCK_WAIT     = 1024;
  localparam int unsigned DEF_SETTLE_CYCLES = 16;
  localparam int unsigned DEF_SLIP_MAX      = 32;
  localparam int unsigned DEF_WIN_FRAMES    = 256;
  localparam int unsigned DEF_FER_BAD_TH    = 8;

endpackage

// File: rtl/fso_align_ctrl_win_mon.sv
// Frame-error-rate window monitor: snapshots the deframer counters and flags a
// window whose CRC-error count exceeds the threshold.
module fso_fer_win_mon
  import fso_align_ctrl_pkg::*;
#(
  parameter int unsigned WIN_FRAMES = DEF_WIN_FRAMES,
  parameter int unsigned FER_BAD_TH = DEF_FER_BAD_TH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_total_frames,
  input  logic [31:0] i_crc_error_frames,
  input  logic        snap_load,
  input  logic        enable,
  output logic        window_bad
);

  logic [31:0] snap_total;
  logic [31:0] snap_crc;
  logic [31:0] frames_d;
  logic [31:0] err_d;
  logic        win_done;

  // Modulo-2^32 differences keep counter wrap from looking like a full window.
  always_comb begin
    frames_d   = i_total_frames - snap_total;
    err_d      = i_crc_error_frames - snap_crc;
    win_done   = enable && (frames_d >= 32'(WIN_FRAMES));
    window_bad = win_done && (err_d > 32'(FER_BAD_TH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_total <= '0;
      snap_crc   <= '0;
    end else if (snap_load || (win_done && !window_bad)) begin
      snap_total <= i_total_frames;
      snap_crc   <= i_crc_error_frames;
    end
  end

endmodule

// File: rtl/fso_align_ctrl.sv
// Link alignment controller: drives deframer soft reset and bit slips until
// frame lock, then supervises lock quality over FER windows.
module fso_align_ctrl
  import fso_align_ctrl_pkg::*;
#(
  parameter int unsigned SRST_CYCLES   = DEF_SRST_CYCLES,
  parameter int unsigned LOCK_WAIT     = DEF_LOCK_WAIT,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned SLIP_MAX      = DEF_SLIP_MAX,
  parameter int unsigned WIN_FRAMES    = DEF_WIN_FRAMES,
  parameter int unsigned FER_BAD_TH    = DEF_FER_BAD_TH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_link_up,
  input  logic        cfg_enable,
  input  logic        cfg_clear,
  input  logic        i_frame_locked,
  input  logic        i_realign_req,
  input  logic [31:0] i_total_frames,
  input  logic [31:0] i_crc_error_frames,
  output logic        o_deframer_srst,
  output logic        o_bitslip,
  output logic        o_aligned,
  output logic        o_fail,
  output logic [2:0]  o_state,
  output logic [7:0]  o_slip_cnt,
  output logic [15:0] o_relock_cnt
);

  state_t      state, state_n;
  logic [31:0] timer, timer_n;
  logic [7:0]  slip_cnt_n;
  logic [15:0] relock_cnt_n;
  logic        relock_hit;
  logic        snap_load;
  logic        win_en;
  logic        window_bad;

  fso_fer_win_mon #(
    .WIN_FRAMES (WIN_FRAMES),
    .FER_BAD_TH (FER_BAD_TH)
  ) u_win_mon (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_total_frames     (i_total_frames),
    .i_crc_error_frames (i_crc_error_frames),
    .snap_load          (snap_load),
    .enable             (win_en),
    .window_bad         (window_bad)
  );

  always_comb begin
    state_n    = state;
    relock_hit = 1'b0;
    if (!i_link_up || !cfg_enable) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      state_n = ST_RESET;
        ST_RESET:     if (timer == 32'(SRST_CYCLES - 1)) state_n = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (i_frame_locked)                    state_n = ST_LOCKED;
          else if (timer == 32'(LOCK_WAIT - 1))  state_n = (o_slip_cnt == 8'(SLIP_MAX)) ? ST_FAIL : ST_SLIP;
        end
        ST_SLIP:      state_n = ST_SETTLE;
        ST_SETTLE:    if (timer == 32'(SETTLE_CYCLES - 1)) state_n = ST_WAIT_LOCK;
        ST_LOCKED: begin
          if (!i_frame_locked || i_realign_req || window_bad) begin
            state_n    = ST_RESET;
            relock_hit = 1'b1;
          end
        end
        ST_FAIL:      if (cfg_clear) state_n = ST_IDLE;
        default:      state_n = ST_IDLE;
      endcase
    end

    timer_n = '0;
    if (state_n == state && (state == ST_RESET || state == ST_WAIT_LOCK || state == ST_SETTLE))
      timer_n = timer + 32'd1;

    slip_cnt_n = o_slip_cnt;
    if (state_n == ST_IDLE || relock_hit) slip_cnt_n = '0;
    else if (state_n == ST_SLIP)          slip_cnt_n = o_slip_cnt + 8'd1;

    relock_cnt_n = o_relock_cnt;
    if (relock_hit && o_relock_cnt != '1) relock_cnt_n = o_relock_cnt + 16'd1;

    snap_load = (state == ST_WAIT_LOCK) && (state_n == ST_LOCKED);
    win_en    = (state == ST_LOCKED);
  end

  // Flag outputs are decoded from the next state so they flip together with o_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      timer           <= '0;
      o_slip_cnt      <= '0;
      o_relock_cnt    <= '0;
      o_deframer_srst <= 1'b1;
      o_bitslip       <= 1'b0;
      o_aligned       <= 1'b0;
      o_fail          <= 1'b0;
    end else begin
      state           <= state_n;
      timer           <= timer_n;
      o_slip_cnt      <= slip_cnt_n;
      o_relock_cnt    <= relock_cnt_n;
      o_deframer_srst <= (state_n == ST_IDLE) || (state_n == ST_RESET) ||
                         (state_n == ST_SETTLE) || (state_n == ST_FAIL);
      o_bitslip       <= (state_n == ST_SLIP);
      o_aligned       <= (state_n == ST_LOCKED);
      o_fail          <= (state_n == ST_FAIL);
    end
  end

  assign o_state = state;

endmodule
